// File: rtl/rv32i_fetch_if.sv
// Fetch-stage bus bundle: redirect input, instruction-memory request/response,
// and the decode-facing {pc, inst} valid/ready channel.
interface rv32i_fetch_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;

    // Fetch stage side
    modport master (
        input  redirect_valid,
        input  redirect_pc,
        output mem_req_valid,
        input  mem_req_ready,
        output mem_req_addr,
        input  mem_resp_valid,
        input  mem_resp_data,
        output inst_valid,
        input  inst_ready,
        output inst_pc,
        output inst_data
    );

    // Environment side: memory, decode and execute redirect source
    modport slave (
        output redirect_valid,
        output redirect_pc,
        input  mem_req_valid,
        output mem_req_ready,
        input  mem_req_addr,
        output mem_resp_valid,
        output mem_resp_data,
        input  inst_valid,
        output inst_ready,
        input  inst_pc,
        input  inst_data
    );
endinterface

// File: rtl/rv32i_fetch.sv
// RV32I instruction fetch: owns the PC, issues credit-limited word fetches, buffers
// in-order responses for decode and squashes stale responses after a redirect.
module rv32i_fetch #(
    parameter logic [31:0] RESET_ADDR  = 32'h0000_0000,
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input logic           clk,
    input logic           rst,
    rv32i_fetch_if.master bus
);
    localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned PW = $clog2(QUEUE_DEPTH);

    typedef logic [CW-1:0] cnt_t;
    typedef logic [PW-1:0] ptr_t;
    typedef enum logic [0:0] {StFetch, StFlush} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    cnt_t        outstanding_q, outstanding_d;
    cnt_t        discard_q, discard_d;
    cnt_t        count_q, count_d;
    ptr_t        head_q, head_d;
    ptr_t        tail_q, tail_d;
    ptr_t        iss_wr_q, iss_wr_d;
    ptr_t        iss_rd_q, iss_rd_d;

    logic [31:0] q_pc   [QUEUE_DEPTH];
    logic [31:0] q_data [QUEUE_DEPTH];
    // PC of each live (non-stale) outstanding request, in issue order
    logic [31:0] iss_pc [QUEUE_DEPTH];

    logic        req_valid;
    logic        req_fire;
    logic        resp;
    logic        push;
    logic        pop;
    logic        iss_we;
    logic        q_we;
    logic        credit_ok;
    logic [CW:0] inflight;
    cnt_t        outstanding_nxt;
    logic        unused_redirect_lsb;

    assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

    // Credit counts buffered entries too, so every response is guaranteed a slot
    assign inflight  = {1'b0, outstanding_q} + {1'b0, count_q};
    assign credit_ok = inflight < (CW + 1)'(QUEUE_DEPTH);
    assign req_valid = !rst && (state_q == StFetch) && credit_ok;
    assign req_fire  = req_valid && bus.mem_req_ready;
    assign resp      = bus.mem_resp_valid;
    assign pop       = (count_q != '0) && bus.inst_ready;
    assign push      = resp && (state_q == StFetch) && !bus.redirect_valid;

    assign outstanding_nxt = outstanding_q + cnt_t'(req_fire) - cnt_t'(resp);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        outstanding_d = outstanding_nxt;
        discard_d     = discard_q;
        count_d       = count_q;
        head_d        = head_q;
        tail_d        = tail_q;
        iss_wr_d      = iss_wr_q;
        iss_rd_d      = iss_rd_q;
        iss_we        = 1'b0;
        q_we          = 1'b0;

        if (bus.redirect_valid) begin
            // Everything still in flight, including a request accepted now, is stale
            pc_d      = {bus.redirect_pc[31:2], 2'b00};
            count_d   = '0;
            head_d    = '0;
            tail_d    = '0;
            iss_wr_d  = '0;
            iss_rd_d  = '0;
            discard_d = outstanding_nxt;
            state_d   = (outstanding_nxt != '0) ? StFlush : StFetch;
        end else begin
            if (req_fire) begin
                pc_d     = pc_q + 32'd4;
                iss_we   = 1'b1;
                iss_wr_d = iss_wr_q + ptr_t'(1);
            end

            if ((state_q == StFlush) && resp) begin
                discard_d = discard_q - cnt_t'(1);
                if (discard_q == cnt_t'(1)) begin
                    state_d = StFetch;
                end
            end

            if (push) begin
                q_we     = 1'b1;
                tail_d   = tail_q + ptr_t'(1);
                iss_rd_d = iss_rd_q + ptr_t'(1);
            end

            if (pop) begin
                head_d = head_q + ptr_t'(1);
            end

            count_d = count_q + cnt_t'(push) - cnt_t'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StFetch;
            pc_q          <= RESET_ADDR;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            iss_wr_q      <= '0;
            iss_rd_q      <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            iss_wr_q      <= iss_wr_d;
            iss_rd_q      <= iss_rd_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the counters and pointers
    always_ff @(posedge clk) begin
        if (iss_we) begin
            iss_pc[iss_wr_q] <= pc_q;
        end
        if (q_we) begin
            q_pc[tail_q]   <= iss_pc[iss_rd_q];
            q_data[tail_q] <= bus.mem_resp_data;
        end
    end

    assign bus.mem_req_valid = req_valid;
    assign bus.mem_req_addr  = pc_q;
    assign bus.inst_valid    = (count_q != '0);
    assign bus.inst_pc       = q_pc[head_q];
    assign bus.inst_data     = q_data[head_q];

    a_resp_has_request: assert property (
        @(posedge clk) disable iff (rst) bus.mem_resp_valid |-> (outstanding_q != '0));

    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst) (push && !pop) |-> (count_q != cnt_t'(QUEUE_DEPTH)));
endmodule
